// File: rtl/vector_assemble.sv
// Byte-to-word assembler: gathers four bytes from a valid/ready byte stream
// and presents them as one 32-bit word on a valid/ready word port.

module vector_assemble_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             ld_i,
  input  logic [VEC_W-1:0] byte_i,
  output logic [VEC_W-1:0] word_o
);
  logic [VEC_W-1:0] buf_q, word_q;

  // On completion the lane written this cycle bypasses its buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      word_q <= '0;
    end else begin
      if (wr_i) buf_q  <= byte_i;
      if (ld_i) word_q <= wr_i ? byte_i : buf_q;
    end
  end

  assign word_o = word_q;
endmodule

module vector_assemble #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  byte_cnt
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {FILL, FULL} state_e;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic accept, xfer, complete;
  logic [1:0] lane_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] word_lanes;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign complete  = accept & (cnt_q == 2'd3);
  // ~cnt equals 3-cnt: first byte goes to the top lane when MSB_FIRST.
  assign lane_sel  = MSB_FIRST ? ~cnt_q : cnt_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vector_assemble_lane #(.VEC_W(VEC_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_i   (accept && (lane_sel == 2'(i))),
      .ld_i   (complete),
      .byte_i (in_byte),
      .word_o (word_lanes[i])
    );
  end

  assign out_word = word_lanes;
  assign byte_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) cnt_d = cnt_q + 2'd1;
    case (state_q)
      FILL:    if (complete) state_d = FULL;
      FULL:    if (xfer && !complete) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vector_assemble.sv
// Bench for vector_assemble: directed table, hand sequences for backpressure
// and reset, then random traffic against a byte-queue reference model.

module tb_vector_assemble;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_byte = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_word1, out_word0;
  logic [1:0] byte_cnt1, byte_cnt0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vector_assemble #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready1), .out_word(out_word1), .out_valid(out_valid1),
    .out_ready(out_ready), .byte_cnt(byte_cnt1));

  vector_assemble #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready0), .out_word(out_word0), .out_valid(out_valid0),
    .out_ready(out_ready), .byte_cnt(byte_cnt0));

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        ordy;
    logic [1:0]  cnt;
    logic        ov;
    logic [31:0] w1;
    logic [31:0] w0;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic v, input logic [1:0] cnt,
                     input logic ov, input logic [31:0] w1, input logic [31:0] w0);
    vec_t e;
    e.b = b; e.v = v; e.ordy = 1'b1; e.cnt = cnt; e.ov = ov; e.w1 = w1; e.w0 = w0;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_byte = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic ordy);
    in_byte = b; in_valid = v; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  // reference model state
  logic [7:0]  part[$];
  logic        mv;
  logic [31:0] mw1, mw0;

  initial begin
    // --- reset state
    rst_n = 1'b0;
    #2;
    chk("rst_cnt1", 32'(byte_cnt1), 0);
    chk("rst_ov1",  32'(out_valid1), 0);
    chk("rst_word1", out_word1, 0);
    chk("rst_word0", out_word0, 0);
    do_reset();

    // --- directed table (out_ready held high)
    add(8'h13, 1, 1, 0, 0, 0);
    add(8'hE5, 1, 2, 0, 0, 0);
    add(8'h89, 1, 3, 0, 0, 0);
    add(8'hA8, 1, 0, 1, 32'h13E589A8, 32'hA889E513);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'hF2, 1, 1, 0, 0, 0);
    add(8'h07, 1, 2, 0, 0, 0);
    add(8'hCB, 1, 3, 0, 0, 0);
    add(8'h89, 1, 0, 1, 32'hF207CB89, 32'h89CB07F2);
    add(8'h63, 1, 1, 0, 0, 0);
    add(8'h56, 1, 2, 0, 0, 0);
    add(8'hF0, 1, 3, 0, 0, 0);
    add(8'hB1, 1, 0, 1, 32'h6356F0B1, 32'hB1F05663);
    add(8'h00, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(8'(k), 1, 2'(k % 4), (k % 4) == 0,
          (k == 4) ? 32'h01020304 : 32'h05060708,
          (k == 4) ? 32'h04030201 : 32'h08070605);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h11, 1, 1, 0, 0, 0);
    add(8'h22, 1, 2, 0, 0, 0);
    add(8'hFF, 0, 2, 0, 0, 0);
    add(8'hFF, 0, 2, 0, 0, 0);
    add(8'hFF, 0, 2, 0, 0, 0);
    add(8'h33, 1, 3, 0, 0, 0);
    add(8'h44, 1, 0, 1, 32'h11223344, 32'h44332211);
    add(8'h00, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].b, tbl[i].v, tbl[i].ordy);
      chk($sformatf("tbl%0d_cnt1", i), 32'(byte_cnt1), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_cnt0", i), 32'(byte_cnt0), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ov1", i), 32'(out_valid1), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_ov0", i), 32'(out_valid0), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_w1", i), out_word1, tbl[i].w1);
        chk($sformatf("tbl%0d_w0", i), out_word0, tbl[i].w0);
      end
    end

    // --- backpressure
    drive(8'h00, 1, 1);
    drive(8'hF3, 1, 1);
    drive(8'hD3, 1, 1);
    drive(8'h04, 1, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", 32'(out_valid1), 1);
      chk("bp_word", out_word1, 32'h00F3D304);
      chk("bp_cnt", 32'(byte_cnt1), 0);
      in_byte = 8'h55; in_valid = 1'b1; out_ready = 1'b0; #1;
      chk("bp_ready", 32'(in_ready1), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready1), 1);
    @(posedge clk); #1;
    chk("bp_after_cnt", 32'(byte_cnt1), 1);
    chk("bp_after_ov", 32'(out_valid1), 0);
    in_valid = 1'b0;

    // --- mid-word asynchronous reset
    do_reset();
    out_ready = 1'b1;
    drive(8'hAA, 1, 1);
    drive(8'hBB, 1, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cnt", 32'(byte_cnt1), 0);
    chk("mrst_ov", 32'(out_valid1), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(8'hCC, 1, 1);
    drive(8'hDD, 1, 1);
    drive(8'hEE, 1, 1);
    drive(8'hFF, 1, 0);
    chk("mrst_word1", out_word1, 32'hCCDDEEFF);
    chk("mrst_word0", out_word0, 32'hFFEEDDCC);
    chk("mrst_ov_full", 32'(out_valid1), 1);
    // reset while holding a full word: nothing emitted afterwards
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("frst_ov", 32'(out_valid1), 0);
    #1 rst_n = 1'b1;
    repeat (3) drive(8'h00, 0, 1);
    chk("frst_ov_after", 32'(out_valid1), 0);

    // --- random traffic vs reference model
    do_reset();
    part.delete(); mv = 1'b0; mw1 = '0; mw0 = '0;
    for (int n = 0; n < 3000; n++) begin
      logic acc, xf;
      in_byte   = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_ready1", 32'(in_ready1), 32'(!mv || out_ready));
      chk("rnd_ready0", 32'(in_ready0), 32'(!mv || out_ready));
      acc = in_valid && (!mv || out_ready);
      xf  = mv && out_ready;
      if (xf) mv = 1'b0;
      if (acc) begin
        part.push_back(in_byte);
        if (part.size() == 4) begin
          mw1 = {part[0], part[1], part[2], part[3]};
          mw0 = {part[3], part[2], part[1], part[0]};
          mv  = 1'b1;
          part.delete();
        end
      end
      @(posedge clk); #1;
      chk("rnd_cnt1", 32'(byte_cnt1), part.size());
      chk("rnd_cnt0", 32'(byte_cnt0), part.size());
      chk("rnd_ov1", 32'(out_valid1), 32'(mv));
      chk("rnd_ov0", 32'(out_valid0), 32'(mv));
      if (mv) begin
        chk("rnd_w1", out_word1, mw1);
        chk("rnd_w0", out_word0, mw0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
